// File: rtl/lvds_tx.sv
// lvds_tx: 2-bit DDR I/Q transmit serializer.
// Prefetches 32-bit I/Q words from an upstream FIFO and shifts each one out
// MSB-first as 16 two-bit symbols, frames back-to-back while data lasts.
module lvds_tx #(
  parameter bit         FORCE_SYNC  = 1'b1,
  parameter logic [1:0] IDLE_SYMBOL = 2'b00
) (
  input  logic        i_ddr_clk,
  input  logic        i_reset,
  input  logic        i_tx_en,
  input  logic        i_fifo_empty,
  input  logic [31:0] i_fifo_data,
  output logic        o_fifo_pull,
  output logic [1:0]  o_ddr_data,
  output logic        o_busy,
  output logic        o_frame_start,
  output logic        o_underrun
);

  // An idle symbol equal to the I sync pattern would fake a frame start at the receiver.
  if (IDLE_SYMBOL == 2'b10) begin : g_bad_idle
    $error("lvds_tx: IDLE_SYMBOL must not equal the I sync pattern 2'b10");
  end

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_TX   = 1'b1
  } state_t;

  state_t      state, state_nxt;
  logic [31:0] shifter, shifter_nxt;
  logic [3:0]  counter, counter_nxt;
  logic        frame_end, frame_end_nxt;

  logic [31:0] r_next;
  logic        r_next_valid;
  logic        r_pull_pending;
  logic [31:0] fifo_word;

  logic [1:0]  ddr_nxt;
  logic        busy_nxt;
  logic        start_nxt;
  logic        underrun_nxt;
  logic        load;

  // Stamp the sync fields onto the incoming word when FORCE_SYNC is set.
  always_comb begin
    fifo_word = i_fifo_data;
    if (FORCE_SYNC) begin
      fifo_word[31:30] = 2'b10;
      fifo_word[15:14] = 2'b01;
    end
  end

  // Single outstanding read: only pull when the prefetch slot is free and no read is in flight.
  // Gated by reset so the FIFO is never popped while the block is being cleared.
  assign o_fifo_pull = !i_reset && !r_next_valid && !r_pull_pending &&
                       !i_fifo_empty && i_tx_en;

  // Prefetch slot: capture the FIFO word one cycle after the pull, release it on frame load.
  always_ff @(posedge i_ddr_clk) begin
    if (i_reset) begin
      // NOTE: r_next is a plain data register; clearing it is cheap and keeps a
      // discarded in-flight word from ever reappearing after reset.
      r_next         <= '0;
      r_next_valid   <= 1'b0;
      r_pull_pending <= 1'b0;
    end else begin
      if (r_pull_pending) begin
        r_next         <= fifo_word;
        r_next_valid   <= 1'b1;
        r_pull_pending <= 1'b0;
      end else if (o_fifo_pull) begin
        r_pull_pending <= 1'b1;
      end
      // A load only happens while r_next_valid=1, which excludes a pending capture.
      if (load) begin
        r_next_valid <= 1'b0;
      end
    end
  end

  // Next-state and next-output logic for the framing FSM.
  always_comb begin
    // NOTE: every signal gets a default here so no path can infer a latch.
    state_nxt     = state;
    shifter_nxt   = shifter;
    counter_nxt   = counter;
    frame_end_nxt = 1'b0;
    ddr_nxt       = IDLE_SYMBOL;
    busy_nxt      = 1'b0;
    start_nxt     = 1'b0;
    underrun_nxt  = 1'b0;
    load          = 1'b0;

    unique case (state)
      ST_IDLE: begin
        if (r_next_valid && i_tx_en) begin
          load        = 1'b1;
          ddr_nxt     = r_next[31:30];
          shifter_nxt = {r_next[29:0], 2'b00};
          counter_nxt = 4'd14;
          start_nxt   = 1'b1;
          busy_nxt    = 1'b1;
          state_nxt   = ST_TX;
        end else begin
          // Only the cycle right after a frame can report a starved link.
          underrun_nxt = frame_end && i_tx_en;
        end
      end
      ST_TX: begin
        ddr_nxt     = shifter[31:30];
        shifter_nxt = {shifter[29:0], 2'b00};
        busy_nxt    = 1'b1;
        if (counter == 4'd0) begin
          state_nxt     = ST_IDLE;
          frame_end_nxt = 1'b1;
        end else begin
          counter_nxt = counter - 4'd1;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // State, datapath and registered outputs.
  always_ff @(posedge i_ddr_clk) begin
    if (i_reset) begin
      state         <= ST_IDLE;
      shifter       <= '0;
      counter       <= '0;
      frame_end     <= 1'b0;
      o_ddr_data    <= IDLE_SYMBOL;
      o_busy        <= 1'b0;
      o_frame_start <= 1'b0;
      o_underrun    <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register updates from pre-edge values.
      state         <= state_nxt;
      shifter       <= shifter_nxt;
      counter       <= counter_nxt;
      frame_end     <= frame_end_nxt;
      o_ddr_data    <= ddr_nxt;
      o_busy        <= busy_nxt;
      o_frame_start <= start_nxt;
      o_underrun    <= underrun_nxt;
    end
  end

endmodule

// File: tb/tb_lvds_tx.sv
// tb_lvds_tx: directed bench for lvds_tx with a small FIFO model.
// A second instance with FORCE_SYNC=0 shares all stimulus for the verbatim check.
module tb_lvds_tx;

  localparam logic [1:0] IDLE = 2'b00;

  logic        clk = 1'b0;
  logic        i_reset;
  logic        i_tx_en;
  logic        fifo_empty;
  logic [31:0] fifo_data = '0;

  logic        o_fifo_pull, o_busy, o_frame_start, o_underrun;
  logic [1:0]  o_ddr_data;
  logic        raw_pull, raw_busy, raw_start, raw_underrun;
  logic [1:0]  raw_data;

  always #5 clk = ~clk;

  lvds_tx #(.FORCE_SYNC(1'b1), .IDLE_SYMBOL(IDLE)) dut (
    .i_ddr_clk     (clk),
    .i_reset       (i_reset),
    .i_tx_en       (i_tx_en),
    .i_fifo_empty  (fifo_empty),
    .i_fifo_data   (fifo_data),
    .o_fifo_pull   (o_fifo_pull),
    .o_ddr_data    (o_ddr_data),
    .o_busy        (o_busy),
    .o_frame_start (o_frame_start),
    .o_underrun    (o_underrun)
  );

  lvds_tx #(.FORCE_SYNC(1'b0), .IDLE_SYMBOL(IDLE)) dut_raw (
    .i_ddr_clk     (clk),
    .i_reset       (i_reset),
    .i_tx_en       (i_tx_en),
    .i_fifo_empty  (fifo_empty),
    .i_fifo_data   (fifo_data),
    .o_fifo_pull   (raw_pull),
    .o_ddr_data    (raw_data),
    .o_busy        (raw_busy),
    .o_frame_start (raw_start),
    .o_underrun    (raw_underrun)
  );

  // FIFO model: 1-cycle read latency, pointers written by one process each.
  logic [31:0] mem [0:15];
  int wr_ptr = 0;
  int rd_ptr = 0;
  assign fifo_empty = (rd_ptr == wr_ptr);

  int cyc = 0, pull_cyc = 0;
  int pulls = 0, raw_pulls = 0, bad_pulls = 0, starts = 0, underruns = 0;

  // Event monitor and FIFO read port.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (raw_pull) raw_pulls <= raw_pulls + 1;
    if (o_frame_start) starts <= starts + 1;
    if (o_underrun) underruns <= underruns + 1;
    if (o_fifo_pull) begin
      pulls    <= pulls + 1;
      pull_cyc <= cyc;
      if (fifo_empty) bad_pulls <= bad_pulls + 1;
      else begin
        fifo_data <= mem[rd_ptr[3:0]];
        rd_ptr    <= rd_ptr + 1;
      end
    end
  end

  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic push(input logic [31:0] w);
    mem[wr_ptr[3:0]] = w;
    wr_ptr++;
  endtask

  // Wait (bounded) until the first symbol of a frame is on the line.
  task automatic wait_start(input string tag, input int max_cycles);
    int found = 0;
    for (int i = 0; i < max_cycles && found == 0; i++) begin
      if (o_frame_start) found = 1;
      else @(negedge clk);
    end
    check({tag, "_start_seen"}, found, 1);
  endtask

  // Collect 16 symbols starting at the current negedge; optionally drop i_tx_en after symbol drop_at.
  task automatic recv_frame(input int drop_at, output logic [31:0] word,
                            output logic [31:0] raw_word, output int n_start,
                            output int n_busy_low);
    word = '0; raw_word = '0; n_start = 0; n_busy_low = 0;
    for (int i = 0; i < 16; i++) begin
      word     = {word[29:0], o_ddr_data};
      raw_word = {raw_word[29:0], raw_data};
      n_start += int'(o_frame_start);
      n_busy_low += int'(!o_busy);
      if (i == drop_at) i_tx_en = 1'b0;
      @(negedge clk);
    end
  endtask

  initial begin
    logic [31:0] w, rw;
    int ns, nb, snap_u, snap_p, snap_s, idle_bad;

    i_reset = 1'b1;
    i_tx_en = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_data", o_ddr_data, IDLE);
    check("rst_busy", o_busy, 0);
    check("rst_start", o_frame_start, 0);
    check("rst_underrun", o_underrun, 0);

    // Data available during reset must not be pulled.
    i_tx_en = 1'b1;
    push(32'h8001_4002);
    @(negedge clk);
    check("rst_pull_gated", o_fifo_pull, 0);
    check("rst_no_pulls", pulls, 0);

    // Test 1: single frame, latency, underrun.
    i_reset = 1'b0;
    snap_u = underruns;
    wait_start("t1", 8);
    check("t1_latency", cyc - pull_cyc, 3);
    recv_frame(-1, w, rw, ns, nb);
    check("t1_word", w, 32'h8001_4002);
    check("t1_one_start", ns, 1);
    check("t1_busy", nb, 0);
    check("t1_idle_after", o_ddr_data, IDLE);
    check("t1_busy_after", o_busy, 0);
    check("t1_underrun_pulse", o_underrun, 1);
    @(negedge clk);
    check("t1_underrun_once", o_underrun, 0);
    check("t1_underrun_count", underruns - snap_u, 1);

    // Test 2: all-zero word, forced vs verbatim sync.
    push(32'h0000_0000);
    wait_start("t2", 8);
    recv_frame(-1, w, rw, ns, nb);
    check("t2_forced", w, 32'h8000_4000);
    check("t2_verbatim", rw, 32'h0000_0000);
    check("t2_raw_busy_after", raw_busy, 0);
    check("t2_raw_underrun", raw_underrun, 1);
    @(negedge clk);

    // Test 3: three words back-to-back, 48 symbols without a gap.
    snap_p = pulls;
    push(32'hAAAA_AAAA);
    push(32'h8001_4002);
    push(32'hBFFF_7FFF);
    wait_start("t3", 8);
    recv_frame(-1, w, rw, ns, nb);
    check("t3_w0", w, 32'hAAAA_6AAA);
    check("t3_w0_start", ns, 1);
    check("t3_w0_busy", nb, 0);
    recv_frame(-1, w, rw, ns, nb);
    check("t3_w1", w, 32'h8001_4002);
    check("t3_w1_start", ns, 1);
    check("t3_w1_busy", nb, 0);
    recv_frame(-1, w, rw, ns, nb);
    check("t3_w2", w, 32'hBFFF_7FFF);
    check("t3_w2_start", ns, 1);
    check("t3_w2_busy", nb, 0);
    check("t3_underrun", o_underrun, 1);
    check("t3_pulls", pulls - snap_p, 3);
    @(negedge clk);

    // Test 4: i_tx_en dropped mid-frame; held word sent on return.
    push(32'h9234_5678);
    push(32'h8ABC_4DEF);
    wait_start("t4", 8);
    recv_frame(5, w, rw, ns, nb);
    check("t4_w0_complete", w, 32'h9234_5678);
    check("t4_w0_busy", nb, 0);
    snap_u = underruns; snap_s = starts; snap_p = pulls; idle_bad = 0;
    for (int i = 0; i < 20; i++) begin
      if (o_ddr_data !== IDLE || o_busy !== 1'b0) idle_bad++;
      @(negedge clk);
    end
    check("t4_idle_line", idle_bad, 0);
    check("t4_no_start", starts - snap_s, 0);
    check("t4_no_underrun", underruns - snap_u, 0);
    check("t4_no_pull", pulls - snap_p, 0);
    i_tx_en = 1'b1;
    wait_start("t4_resume", 4);
    recv_frame(-1, w, rw, ns, nb);
    check("t4_held_word", w, 32'h8ABC_4DEF);
    check("t4_underrun", o_underrun, 1);
    @(negedge clk);

    // Test 5: reset on symbol 8; prefetched word discarded, next FIFO word follows.
    push(32'hA5A5_5A5A);
    push(32'h8123_4567);
    push(32'h7FFF_0000);
    wait_start("t5", 8);
    repeat (8) @(negedge clk);
    snap_p = pulls;
    i_reset = 1'b1;
    @(negedge clk);
    check("t5_rst_data", o_ddr_data, IDLE);
    check("t5_rst_busy", o_busy, 0);
    check("t5_rst_start", o_frame_start, 0);
    check("t5_rst_pull", o_fifo_pull, 0);
    @(negedge clk);
    check("t5_rst_pull2", o_fifo_pull, 0);
    check("t5_rst_no_pulls", pulls - snap_p, 0);
    i_reset = 1'b0;
    wait_start("t5_after", 8);
    recv_frame(-1, w, rw, ns, nb);
    check("t5_next_word", w, 32'hBFFF_4000);
    check("t5_start", ns, 1);
    repeat (2) @(negedge clk);

    // Test 6: FIFO empty with i_tx_en=1 -> steady idle line.
    snap_u = underruns; snap_s = starts; snap_p = pulls; idle_bad = 0;
    for (int i = 0; i < 40; i++) begin
      if (o_ddr_data !== IDLE) idle_bad++;
      @(negedge clk);
    end
    check("t6_idle_line", idle_bad, 0);
    check("t6_no_pull", pulls - snap_p, 0);
    check("t6_no_start", starts - snap_s, 0);
    check("t6_no_underrun", underruns - snap_u, 0);

    check("total_pulls", pulls, 10);
    check("total_raw_pulls", raw_pulls, 10);
    check("no_empty_pulls", bad_pulls, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
